// File: rtl/l1b_read_arbiter.sv
// L1 buffer read arbiter: fixed-priority grant of a STRB_LEN-cycle read
// window to one of NSRC requesters, with per-source pending latches.
module l1b_read_arbiter #(
    parameter int ADDR_W   = 8,
    parameter int NSRC     = 2,
    parameter int STRB_LEN = 3
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic [NSRC-1:0]            Req,
    input  logic [NSRC*ADDR_W-1:0]     AddrIn,
    output logic [ADDR_W-1:0]          AddrOut,
    output logic [NSRC-1:0]            Grant,
    output logic [STRB_LEN-1:0]        Strob,
    output logic [NSRC*STRB_LEN-1:0]   SrcStrob,
    output logic                       Busy,
    output logic [NSRC-1:0]            Pending,
    output logic                       Overflow
);

    localparam int CW = (STRB_LEN > 1) ? $clog2(STRB_LEN) : 1;
    localparam int SW = (NSRC > 1) ? $clog2(NSRC) : 1;
    localparam logic [CW-1:0] LAST = CW'(STRB_LEN - 1);

    typedef enum logic {IDLE, WIN} state_t;

    state_t                   state;
    logic [CW-1:0]            cnt;
    logic [SW-1:0]            sel;
    logic [NSRC-1:0]          elig;
    logic [NSRC-1:0]          winMask;
    logic [SW-1:0]            winIdx;
    logic                     boundary;
    logic [NSRC*STRB_LEN-1:0] srcNext;

    // Lowest set index wins; winMask is empty off a window boundary
    always_comb begin
        elig     = Pending | Req;
        boundary = (state == IDLE) || (cnt == LAST);
        winMask  = '0;
        winIdx   = '0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (elig[i]) begin
                winMask = NSRC'(1) << i;
                winIdx  = SW'(i);
            end
        end
        if (!boundary) winMask = '0;
    end

    always_comb begin
        Busy = (state == WIN);
        for (int k = 0; k < STRB_LEN; k++)
            Strob[k] = (state == WIN) && (cnt == CW'(k));
        for (int i = 0; i < NSRC; i++)
            for (int k = 0; k < STRB_LEN; k++)
                srcNext[i*STRB_LEN+k] = Strob[k] & Grant[i];
    end

    assign AddrOut = AddrIn[int'(sel)*ADDR_W +: ADDR_W];

    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= IDLE;
            cnt      <= '0;
            sel      <= '0;
            Grant    <= '0;
            Pending  <= '0;
            Overflow <= 1'b0;
            SrcStrob <= '0;
        end else begin
            Overflow <= |(Req & Pending & ~winMask);
            Pending  <= (Pending | Req) & ~winMask;
            SrcStrob <= srcNext;
            if (boundary) begin
                cnt <= '0;
                if (|elig) begin
                    state <= WIN;
                    Grant <= winMask;
                    sel   <= winIdx;
                end else begin
                    state <= IDLE;
                    Grant <= '0;
                end
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_l1b_read_arbiter.sv
// Bench for l1b_read_arbiter: directed vector table, random run against a
// window-level model, and a STRB_LEN=1 instance.
module tb_l1b_read_arbiter;

    logic        clk = 1'b0;
    logic        rst, rst1;
    logic [1:0]  req, req1;
    logic [15:0] addr;

    logic [7:0]  addrOut, addrOut1;
    logic [1:0]  grant, grant1, pend, pend1;
    logic [2:0]  strob;
    logic [0:0]  strob1;
    logic [5:0]  srcStrob;
    logic [1:0]  srcStrob1;
    logic        busy, busy1, ovf, ovf1;

    int nChecks = 0;
    int nFails  = 0;

    always #5 clk = ~clk;

    l1b_read_arbiter #(.ADDR_W(8), .NSRC(2), .STRB_LEN(3)) dut (
        .CLK(clk), .RST(rst), .Req(req), .AddrIn(addr),
        .AddrOut(addrOut), .Grant(grant), .Strob(strob),
        .SrcStrob(srcStrob), .Busy(busy), .Pending(pend),
        .Overflow(ovf)
    );

    l1b_read_arbiter #(.ADDR_W(8), .NSRC(2), .STRB_LEN(1)) dut1 (
        .CLK(clk), .RST(rst1), .Req(req1), .AddrIn(addr),
        .AddrOut(addrOut1), .Grant(grant1), .Strob(strob1),
        .SrcStrob(srcStrob1), .Busy(busy1), .Pending(pend1),
        .Overflow(ovf1)
    );

    typedef struct {
        bit         r;
        logic [1:0] q;
        logic [1:0] g;
        logic [2:0] s;
        logic       b;
        logic [1:0] p;
        logic       o;
        logic [5:0] ss;
        logic [7:0] a;
    } vec_t;

    vec_t vecs[$];

    function automatic void v(bit r, logic [1:0] q, logic [1:0] g,
                              logic [2:0] s, logic b, logic [1:0] p,
                              logic o, logic [5:0] ss, logic [7:0] a);
        vec_t e;
        e.r = r; e.q = q; e.g = g; e.s = s; e.b = b;
        e.p = p; e.o = o; e.ss = ss; e.a = a;
        vecs.push_back(e);
    endfunction

    task automatic check(string name, logic [31:0] got, logic [31:0] exp);
        nChecks++;
        if (got !== exp) begin
            nFails++;
            $display("FAIL %s: got %h required %h", name, got, exp);
        end
    endtask

    function automatic logic [22:0] dutVec();
        return {grant, strob, busy, pend, ovf, srcStrob, addrOut};
    endfunction

    // Window-level reference model (STRB_LEN=3, NSRC=2)
    int         mOwner, mPhase, mLastSel;
    logic [1:0] mPend;
    logic       mOvf;
    logic [5:0] mSrc;

    task automatic modelStep(bit r, logic [1:0] q);
        int win;
        logic [1:0] wm;
        bit bnd;
        if (r) begin
            mOwner = -1; mPhase = 0; mPend = 0;
            mLastSel = 0; mOvf = 0; mSrc = 0;
            return;
        end
        mSrc = (mOwner >= 0) ? 6'(1 << (mOwner * 3 + mPhase)) : 6'd0;
        bnd  = (mOwner < 0) || (mPhase == 2);
        win  = -1;
        if (bnd) begin
            for (int i = 0; i < 2; i++)
                if (win < 0 && (mPend[i] || q[i])) win = i;
        end
        wm    = (win >= 0) ? 2'(1 << win) : 2'b00;
        mOvf  = |(q & mPend & ~wm);
        mPend = (mPend | q) & ~wm;
        if (bnd) begin
            mOwner = win;
            mPhase = 0;
            if (win >= 0) mLastSel = win;
        end else begin
            mPhase++;
        end
    endtask

    function automatic logic [22:0] modelVec();
        logic [1:0] g;
        logic [2:0] s;
        g = (mOwner >= 0) ? 2'(1 << mOwner) : 2'b00;
        s = (mOwner >= 0) ? 3'(1 << mPhase) : 3'b000;
        return {g, s, 1'(mOwner >= 0), mPend, mOvf, mSrc,
                addr[mLastSel*8 +: 8]};
    endfunction

    initial begin
        rst = 1'b1; req = 2'b00; rst1 = 1'b1; req1 = 2'b00;
        addr = 16'h3412;

        // single src0 request
        v(1,2'b00, 2'b00,3'b000,0,2'b00,0,6'b000000,8'h12);
        v(0,2'b01, 2'b01,3'b001,1,2'b00,0,6'b000000,8'h12);
        v(0,2'b00, 2'b01,3'b010,1,2'b00,0,6'b000001,8'h12);
        v(0,2'b00, 2'b01,3'b100,1,2'b00,0,6'b000010,8'h12);
        v(0,2'b00, 2'b00,3'b000,0,2'b00,0,6'b000100,8'h12);
        v(0,2'b00, 2'b00,3'b000,0,2'b00,0,6'b000000,8'h12);
        // both sources at once
        v(0,2'b11, 2'b01,3'b001,1,2'b10,0,6'b000000,8'h12);
        v(0,2'b00, 2'b01,3'b010,1,2'b10,0,6'b000001,8'h12);
        v(0,2'b00, 2'b01,3'b100,1,2'b10,0,6'b000010,8'h12);
        v(0,2'b00, 2'b10,3'b001,1,2'b00,0,6'b000100,8'h34);
        v(0,2'b00, 2'b10,3'b010,1,2'b00,0,6'b001000,8'h34);
        v(0,2'b00, 2'b10,3'b100,1,2'b00,0,6'b010000,8'h34);
        v(0,2'b00, 2'b00,3'b000,0,2'b00,0,6'b100000,8'h34);
        v(0,2'b00, 2'b00,3'b000,0,2'b00,0,6'b000000,8'h34);
        v(1,2'b00, 2'b00,3'b000,0,2'b00,0,6'b000000,8'h12);
        // src1 three times in a row: pending then overflow
        v(0,2'b10, 2'b10,3'b001,1,2'b00,0,6'b000000,8'h34);
        v(0,2'b10, 2'b10,3'b010,1,2'b10,0,6'b001000,8'h34);
        v(0,2'b10, 2'b10,3'b100,1,2'b10,1,6'b010000,8'h34);
        v(0,2'b00, 2'b10,3'b001,1,2'b00,0,6'b100000,8'h34);
        v(0,2'b00, 2'b10,3'b010,1,2'b00,0,6'b001000,8'h34);
        v(0,2'b00, 2'b10,3'b100,1,2'b00,0,6'b010000,8'h34);
        v(0,2'b00, 2'b00,3'b000,0,2'b00,0,6'b100000,8'h34);
        v(0,2'b00, 2'b00,3'b000,0,2'b00,0,6'b000000,8'h34);
        // src0 pre-empts pending src1 at a boundary
        v(0,2'b01, 2'b01,3'b001,1,2'b00,0,6'b000000,8'h12);
        v(0,2'b10, 2'b01,3'b010,1,2'b10,0,6'b000001,8'h12);
        v(0,2'b00, 2'b01,3'b100,1,2'b10,0,6'b000010,8'h12);
        v(0,2'b01, 2'b01,3'b001,1,2'b10,0,6'b000100,8'h12);
        v(0,2'b00, 2'b01,3'b010,1,2'b10,0,6'b000001,8'h12);
        v(0,2'b00, 2'b01,3'b100,1,2'b10,0,6'b000010,8'h12);
        v(0,2'b00, 2'b10,3'b001,1,2'b00,0,6'b000100,8'h34);
        v(0,2'b00, 2'b10,3'b010,1,2'b00,0,6'b001000,8'h34);
        v(0,2'b00, 2'b10,3'b100,1,2'b00,0,6'b010000,8'h34);
        v(0,2'b00, 2'b00,3'b000,0,2'b00,0,6'b100000,8'h34);
        v(0,2'b00, 2'b00,3'b000,0,2'b00,0,6'b000000,8'h34);
        // reset aborts a window and overrides Req
        v(0,2'b01, 2'b01,3'b001,1,2'b00,0,6'b000000,8'h12);
        v(0,2'b00, 2'b01,3'b010,1,2'b00,0,6'b000001,8'h12);
        v(1,2'b01, 2'b00,3'b000,0,2'b00,0,6'b000000,8'h12);
        v(0,2'b00, 2'b00,3'b000,0,2'b00,0,6'b000000,8'h12);
        v(0,2'b00, 2'b00,3'b000,0,2'b00,0,6'b000000,8'h12);

        @(posedge clk); #1;
        for (int i = 0; i < vecs.size(); i++) begin
            rst = vecs[i].r;
            req = vecs[i].q;
            @(posedge clk); #1;
            check($sformatf("vec[%0d]", i), 32'(dutVec()),
                  32'({vecs[i].g, vecs[i].s, vecs[i].b, vecs[i].p,
                       vecs[i].o, vecs[i].ss, vecs[i].a}));
        end

        // random traffic against the model
        rst = 1'b1; req = 2'b00;
        @(posedge clk); modelStep(1'b1, 2'b00); #1;
        for (int n = 0; n < 800; n++) begin
            rst  = ($urandom_range(0, 99) == 0);
            req  = ($urandom_range(0, 2) == 0) ? 2'($urandom) : 2'b00;
            addr = 16'($urandom);
            @(posedge clk);
            modelStep(rst, req);
            #1;
            check($sformatf("rand[%0d]", n), 32'(dutVec()),
                  32'(modelVec()));
        end

        // STRB_LEN=1: every cycle is a boundary
        addr = 16'h3412;
        rst1 = 1'b1; req1 = 2'b00;
        @(posedge clk); #1;
        check("s1 reset",
              32'({grant1, strob1, busy1, pend1, ovf1, srcStrob1, addrOut1}),
              32'({2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 8'h12}));
        rst1 = 1'b0; req1 = 2'b11;
        @(posedge clk); #1;
        check("s1 cyc1",
              32'({grant1, strob1, busy1, pend1, ovf1, srcStrob1, addrOut1}),
              32'({2'b01, 1'b1, 1'b1, 2'b10, 1'b0, 2'b00, 8'h12}));
        req1 = 2'b00;
        @(posedge clk); #1;
        check("s1 cyc2",
              32'({grant1, strob1, busy1, pend1, ovf1, srcStrob1, addrOut1}),
              32'({2'b10, 1'b1, 1'b1, 2'b00, 1'b0, 2'b01, 8'h34}));
        @(posedge clk); #1;
        check("s1 cyc3",
              32'({grant1, strob1, busy1, pend1, ovf1, srcStrob1, addrOut1}),
              32'({2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 2'b10, 8'h34}));
        @(posedge clk); #1;
        check("s1 cyc4",
              32'({grant1, strob1, busy1, pend1, ovf1, srcStrob1, addrOut1}),
              32'({2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 8'h34}));

        $display("End of test - %0d assertions evaluated, %0d failures",
                 nChecks, nFails);
        $finish;
    end

endmodule

// File: doc/l1b_read_arbiter.md
L1B_READ_ARBITER -- requirements
Module: l1b_read_arbiter

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 Parameter SHALL be ADDR_W, default 8, width of the L1 buffer read address.
REQ-003 Parameter SHALL be NSRC, default 2, number of readout request sources (minimum 1).
REQ-004 Parameter SHALL be STRB_LEN, default 3, read-strobe stretch length in BCs (minimum 1).
REQ-005 Port SHALL be CLK  input  1  BC clock; all state updates on rising edge.
REQ-006 Port SHALL be RST  input  1  synchronous active-high reset.
REQ-007 Port SHALL be Req  input  NSRC  per-source single-cycle read request.
REQ-008 Port SHALL be AddrIn  input  NSRC*ADDR_W  per-source read address; source i occupies bits [i*ADDR_W +: ADDR_W].
REQ-009 Port SHALL be AddrOut  output  ADDR_W  selected read address, a combinational mux of AddrIn by registered Sel.
REQ-010 Port SHALL be Grant  output  NSRC  one-hot source owning the current window; zero when idle.
REQ-011 Port SHALL be Strob  output  STRB_LEN  window phase strobes; bit k is high in window cycle k.
REQ-012 Port SHALL be SrcStrob  output  NSRC*STRB_LEN  per-source phase strobes; bit i*STRB_LEN+k is Strob[k]&Grant[i] registered one cycle.
REQ-013 Port SHALL be Busy  output  1  window in progress.
REQ-014 Port SHALL be Pending  output  NSRC  latched requests awaiting a window.
REQ-015 Port SHALL be Overflow  output  1  one-cycle pulse when a request is dropped.

Function
REQ-016 State machine SHALL have two states, IDLE and WIN, plus phase counter cnt of width max(1,clog2(STRB_LEN)).
REQ-017 Eligible set SHALL be Pending | Req, evaluated at each edge.
REQ-018 At an edge in IDLE, or in WIN with cnt==STRB_LEN-1, a nonzero eligible set SHALL start a window: lowest index i wins; Grant=1<<i, Sel=i, cnt=0, state WIN.
REQ-019 In that same case, the winner's Pending bit SHALL clear; every other Req bit SHALL set its Pending bit.
REQ-020 In WIN with cnt<STRB_LEN-1, cnt SHALL increment and Grant/Sel SHALL hold.
REQ-021 At cnt==STRB_LEN-1 with empty eligible set, the FSM SHALL go to IDLE with Grant=0, Sel held (AddrOut keeps last source).
REQ-022 Consecutive windows SHALL be back-to-back with no idle gap.
REQ-023 Latency SHALL be: Req sampled at edge t while idle -> Grant, Busy, Strob[0] high at cycle t+1 -> SrcStrob phase 0 at t+2.
REQ-024 Strob[k] SHALL equal (state==WIN && cnt==k); Busy SHALL equal (state==WIN).
REQ-025 Req[i] arriving while not winning SHALL set Pending[i], including when i owns the current window.
REQ-026 Req[i] with Pending[i] already 1 and i not winning SHALL be dropped, Pending[i] stays 1, and Overflow SHALL pulse the next cycle.
REQ-027 Arbitration SHALL be fixed priority (index 0 highest), and starvation of higher indices under sustained load SHALL be permitted.
REQ-028 With STRB_LEN==1, every cycle SHALL be a window boundary.

Reset
REQ-029 RST high at an edge SHALL clear state to IDLE and clear cnt, Sel, Grant, Strob, SrcStrob, Busy, Pending, and Overflow, so AddrOut=AddrIn[0].
REQ-030 RST SHALL override Req in the same cycle and abort any window mid-operation with no further strobes.

Verification (NSRC=2, STRB_LEN=3, ADDR_W=8 unless stated)
REQ-031 Req=01 at edge 0, AddrIn0=0x12 -> cycles 1-3 Strob=001/010/100, Grant=01, AddrOut=0x12, Busy=1; SrcStrob[2:0] phases at cycles 2-4; idle at cycle 4.
REQ-032 Req=11 at edge 0 -> src0 window cycles 1-3 with Pending=10; src1 window cycles 4-6, with AddrOut switching to AddrIn1 at cycle 4.
REQ-033 Req[1] at edges 0, 1, 2 -> window 1-3, Pending[1]=1 from cycle 2, Overflow=1 at cycle 3 only, second src1 window cycles 4-6, then idle.
REQ-034 Req[1] at edge 1 during src0 window, Req[0] at edge 3 -> src0 window cycles 4-6, then src1 window cycles 7-9.
REQ-035 RST at edge 2 during a window -> cycle 3 all outputs 0, Pending=00, AddrOut=AddrIn0; no SrcStrob after cycle 3.
REQ-036 STRB_LEN=1, Req=11 at edge 0 -> Grant 01 at cycle 1, Grant 10 at cycle 2, idle at cycle 3.
